mlp_layer_sequencer: RTL and testbench
======================================

// Module: mlp_layer_sequencer
// PURPOSE
//  Control FSM that time-multiplexes the single shared neuron datapath across all
//  (M-1) layers x N neurons of the MLP. Sequences the memory read, the neuron
//  compute window and the result write-back for each neuron, in order. Swaps the
//  layer ping-pong buffer at every layer boundary. Signals completion with a
//  start/busy/done handshake. Sits between the top-level MLP wrapper and the
//  memory + single-neuron pair; it replaces the free-running flag-driven control.
// PARAMETERS
//  M        3  number of layers incl. input layer; computed layers = M-1; M>=3
//  N        3  neurons per layer (= inputs per neuron); N>=2
//  NEU_LAT  2  neuron compute latency in cycles, from read_en to result valid; >=1
// PORTS
//  clk          in   1                  clock, all state updates on rising edge
//  rst          in   1                  async reset, active-high
//  start        in   1                  request one full inference; sampled in IDLE only
//  abort        in   1                  synchronous cancel; returns to IDLE, no done
//  load_inputs  out  1                  1-cycle strobe: memory captures external x[]
//  read_en      out  1                  memory read of weights/bias at layer_addr/neuron_addr
//  write_en     out  1                  memory writes neuron result at layer_addr/neuron_addr
//  swap_buf     out  1                  1-cycle strobe: layer outputs become next inputs
//  layer_addr   out  $clog2(M-1)        current computed layer, 0..M-2
//  neuron_addr  out  $clog2(N)          current neuron in layer, 0..N-1
//  busy         out  1                  high in every state except IDLE
//  done         out  1                  1-cycle pulse; outputs[] valid from this cycle
// BEHAVIOUR
//  Reset: state=IDLE; all strobes, busy, done = 0; layer_addr = neuron_addr = 0.
//   Reset asserted mid-inference aborts immediately; no done is produced.
//  All outputs are registered (Moore). Addresses are held stable for the whole
//   READ..WRITE span of a neuron.
//  States and transitions:
//   IDLE    : start & !abort -> LOAD; else stay. Addresses are held at 0.
//   LOAD    : load_inputs=1 -> READ.
//   READ    : read_en=1, one cycle -> COMP; latency counter cleared.
//   COMP    : counter 0..NEU_LAT-1; at NEU_LAT-1 -> WRITE.
//   WRITE   : write_en=1. Exit depends on position:
//             neuron<N-1: neuron++ -> READ.
//             neuron==N-1 & layer<M-2: -> SWAP.
//             neuron==N-1 & layer==M-2: -> DONE.
//   SWAP    : swap_buf=1, layer++, neuron=0 -> READ.
//   DONE    : done=1, busy=1 for one cycle -> IDLE. layer_addr and neuron_addr
//             return to 0 on entry to IDLE.
//  Counter widths: neuron/layer counters never wrap past N-1 / M-2.
//   The latency counter is $clog2(NEU_LAT+1) bits wide.
//  Latency: start sampled at edge 0 -> done high in cycle
//   T = 2 + (M-1)*N*(NEU_LAT+2) + (M-2).
//  start while busy: ignored, never queued. start held high through DONE
//   re-triggers only after IDLE is reached (one IDLE cycle minimum).
//  abort in any non-IDLE state: next state IDLE. All strobes drop next cycle and
//   no done is produced. abort & start together in IDLE: abort wins.
//  At most one of load_inputs/read_en/write_en/swap_buf/done is high per cycle.
// TESTING
//  1 Reset: rst=1 mid-COMP -> all outputs 0 the same cycle, IDLE after release.
//  2 Full run M=3,N=3,NEU_LAT=2: start pulse -> done in cycle 27.
//    6 read_en, 6 write_en and 1 swap_buf are seen.
//    (layer,neuron) order: (0,0)(0,1)(0,2)(1,0)(1,1)(1,2).
//  3 start pulsed at cycles 5 and 12 while busy -> still exactly one done,
//    still at cycle 27.
//  4 abort during layer1/neuron1 COMP -> IDLE next cycle, no write_en and no done.
//    A new start then completes normally in 27 cycles.
//  5 start held high constantly -> done pulses are 28 cycles apart, each followed
//    by exactly one IDLE cycle.
//  6 M=4,N=2,NEU_LAT=1: done at cycle 2+3*2*3+2 = 22; exactly 2 swap_buf strobes.
//  Assertions: strobes mutually exclusive; addresses stay in range; busy = state!=IDLE.

Source files
------------

// File: rtl/mlp_layer_sequencer_if.sv
// Handshake and address bundle between the MLP wrapper (master) and the
// layer sequencer (slave).
interface mlp_layer_sequencer_if #(
  parameter int M = 3,
  parameter int N = 3
);
  localparam int LW = $clog2(M - 1);
  localparam int NW = $clog2(N);

  logic          start;
  logic          abort;
  logic          load_inputs;
  logic          read_en;
  logic          write_en;
  logic          swap_buf;
  logic [LW-1:0] layer_addr;
  logic [NW-1:0] neuron_addr;
  logic          busy;
  logic          done;

  modport master (
    output start, abort,
    input  load_inputs, read_en, write_en, swap_buf,
    input  layer_addr, neuron_addr, busy, done
  );

  modport slave (
    input  start, abort,
    output load_inputs, read_en, write_en, swap_buf,
    output layer_addr, neuron_addr, busy, done
  );
endinterface

// File: rtl/mlp_layer_sequencer.sv
// Moore FSM sharing one neuron datapath over all computed layers: per neuron
// READ -> COMP (NEU_LAT cycles) -> WRITE, with a buffer swap between layers.
module mlp_layer_sequencer_chk #(
  parameter int M  = 3,
  parameter int N  = 3,
  parameter int LW = 1,
  parameter int NW = 2
) (
  input logic          clk,
  input logic          rst,
  input logic          not_idle,
  input logic          busy,
  input logic [4:0]    strobes,
  input logic [LW-1:0] layer_addr,
  input logic [NW-1:0] neuron_addr
);
  a_strobe_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(strobes));
  a_layer_range:   assert property (@(posedge clk) disable iff (rst) int'(layer_addr) <= M - 2);
  a_neuron_range:  assert property (@(posedge clk) disable iff (rst) int'(neuron_addr) <= N - 1);
  a_busy_state:    assert property (@(posedge clk) disable iff (rst) busy == not_idle);
endmodule

module mlp_layer_sequencer #(
  parameter int M       = 3,
  parameter int N       = 3,
  parameter int NEU_LAT = 2
) (
  input logic                  clk,
  input logic                  rst,
  mlp_layer_sequencer_if.slave bus
);
  localparam int LW   = $clog2(M - 1);
  localparam int NW   = $clog2(N);
  localparam int LATW = $clog2(NEU_LAT + 1);
  localparam logic [LW-1:0]   LAYER_LAST  = LW'(M - 2);
  localparam logic [NW-1:0]   NEURON_LAST = NW'(N - 1);
  localparam logic [LATW-1:0] LAT_LAST    = LATW'(NEU_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_READ, S_COMP, S_WRITE, S_SWAP, S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [LW-1:0]   layer_q, layer_d;
  logic [NW-1:0]   neuron_q, neuron_d;
  logic [LATW-1:0] lat_q, lat_d;
  logic            load_q, load_d, read_q, read_d, write_q, write_d;
  logic            swap_q, swap_d, busy_q, busy_d, done_q, done_d;

  // Next-state, address counters and the registered Moore outputs of the next state.
  always_comb begin
    state_d  = state_q;
    layer_d  = layer_q;
    neuron_d = neuron_q;
    lat_d    = lat_q;
    if (bus.abort) begin
      // abort also masks a simultaneous start while idle
      state_d  = S_IDLE;
      layer_d  = '0;
      neuron_d = '0;
      lat_d    = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          layer_d  = '0;
          neuron_d = '0;
          if (bus.start) begin
            state_d = S_LOAD;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_LOAD: state_d = S_READ;
        S_READ: begin
          lat_d   = '0;
          state_d = S_COMP;
        end
        S_COMP: begin
          if (lat_q == LAT_LAST) begin
            state_d = S_WRITE;
          end else begin
            lat_d = lat_q + LATW'(1);
          end
        end
        S_WRITE: begin
          if (neuron_q != NEURON_LAST) begin
            neuron_d = neuron_q + NW'(1);
            state_d  = S_READ;
          end else if (layer_q != LAYER_LAST) begin
            state_d = S_SWAP;
          end else begin
            state_d = S_DONE;
          end
        end
        S_SWAP: begin
          layer_d  = layer_q + LW'(1);
          neuron_d = '0;
          state_d  = S_READ;
        end
        S_DONE: begin
          layer_d  = '0;
          neuron_d = '0;
          state_d  = S_IDLE;
        end
        default: begin
          layer_d  = '0;
          neuron_d = '0;
          lat_d    = '0;
          state_d  = S_IDLE;
        end
      endcase
    end
    load_d  = (state_d == S_LOAD);
    read_d  = (state_d == S_READ);
    write_d = (state_d == S_WRITE);
    swap_d  = (state_d == S_SWAP);
    done_d  = (state_d == S_DONE);
    busy_d  = (state_d != S_IDLE);
  end

  // State, counters and output flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      layer_q  <= '0;
      neuron_q <= '0;
      lat_q    <= '0;
      load_q   <= 1'b0;
      read_q   <= 1'b0;
      write_q  <= 1'b0;
      swap_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      layer_q  <= layer_d;
      neuron_q <= neuron_d;
      lat_q    <= lat_d;
      load_q   <= load_d;
      read_q   <= read_d;
      write_q  <= write_d;
      swap_q   <= swap_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.load_inputs = load_q;
  assign bus.read_en     = read_q;
  assign bus.write_en    = write_q;
  assign bus.swap_buf    = swap_q;
  assign bus.layer_addr  = layer_q;
  assign bus.neuron_addr = neuron_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;

  mlp_layer_sequencer_chk #(.M(M), .N(N), .LW(LW), .NW(NW)) u_chk (
    .clk         (clk),
    .rst         (rst),
    .not_idle    (state_q != S_IDLE),
    .busy        (busy_q),
    .strobes     ({load_q, read_q, write_q, swap_q, done_q}),
    .layer_addr  (layer_q),
    .neuron_addr (neuron_q)
  );
endmodule

// File: tb/tb_mlp_layer_sequencer.sv
// Directed bench for mlp_layer_sequencer: one instance at M=3,N=3,NEU_LAT=2
// and one at M=4,N=2,NEU_LAT=1, sharing clock and reset.
module tb_mlp_layer_sequencer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mlp_layer_sequencer_if #(.M(3), .N(3)) b3();
  mlp_layer_sequencer_if #(.M(4), .N(2)) b4();

  mlp_layer_sequencer #(.M(3), .N(3), .NEU_LAT(2)) dut3 (.clk(clk), .rst(rst), .bus(b3.slave));
  mlp_layer_sequencer #(.M(4), .N(2), .NEU_LAT(1)) dut4 (.clk(clk), .rst(rst), .bus(b4.slave));

  int n_pass = 0;
  int n_checks = 0;
  int done_q[$];
  int rd_q[$];
  int n_ld, n_rd, n_wr, n_sw;
  bit busy_h [0:127];

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic drive(input int sel, input bit s, input bit a);
    if (sel == 1) begin
      b4.start = s;
      b4.abort = a;
    end else begin
      b3.start = s;
      b3.abort = a;
    end
  endtask

  // Issues start (sampled at edge 0), then observes cycles 1..budget;
  // cycle c is the interval right after edge c-1.
  task automatic run(input int sel, input int budget, input bit hold,
                     input int p1, input int p2, input int abort_at);
    int ld, rd, wr, sw, dn, bz, la, na;
    done_q.delete();
    rd_q.delete();
    n_ld = 0; n_rd = 0; n_wr = 0; n_sw = 0;
    @(negedge clk);
    drive(sel, 1'b1, 1'b0);
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (sel == 1) begin
        ld = b4.load_inputs; rd = b4.read_en; wr = b4.write_en; sw = b4.swap_buf;
        dn = b4.done; bz = b4.busy; la = int'(b4.layer_addr); na = int'(b4.neuron_addr);
      end else begin
        ld = b3.load_inputs; rd = b3.read_en; wr = b3.write_en; sw = b3.swap_buf;
        dn = b3.done; bz = b3.busy; la = int'(b3.layer_addr); na = int'(b3.neuron_addr);
      end
      busy_h[c] = bz[0];
      n_ld += ld; n_rd += rd; n_wr += wr; n_sw += sw;
      if (rd != 0) rd_q.push_back(la * 4 + na);
      if (dn != 0) done_q.push_back(c);
      if (c == abort_at) begin
        check("abort_at_layer", la, 1);
        check("abort_at_neuron", na, 1);
        check("abort_in_comp", rd + wr, 0);
      end
      drive(sel, hold || (c == p1) || (c == p2), c == abort_at);
    end
    drive(sel, 1'b0, 1'b1);
    @(negedge clk);
    drive(sel, 1'b0, 1'b0);
    @(negedge clk);
  endtask

  initial begin
    int exp_order [6];
    exp_order = '{0, 1, 2, 4, 5, 6};
    rst = 1'b1;
    drive(0, 1'b0, 1'b0);
    drive(1, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", b3.busy, 0);
    check("rst_strobes", {b3.load_inputs, b3.read_en, b3.write_en, b3.swap_buf, b3.done}, 0);
    check("rst_addr", {b3.layer_addr, b3.neuron_addr}, 0);

    // Test 1: async reset in the middle of COMP
    b3.start = 1'b1;
    @(negedge clk);
    b3.start = 1'b0;
    check("t1_load", b3.load_inputs, 1);
    repeat (2) @(negedge clk);
    check("t1_comp_busy", b3.busy, 1);
    #2 rst = 1'b1;
    #1;
    check("t1_rst_busy_now", b3.busy, 0);
    check("t1_rst_outs_now", {b3.load_inputs, b3.read_en, b3.write_en, b3.swap_buf, b3.done}, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("t1_idle_after", {b3.busy, b3.done, b3.load_inputs}, 0);

    // Test 2: full run
    run(0, 40, 1'b0, -1, -1, -1);
    check("t2_n_done", done_q.size(), 1);
    if (done_q.size() > 0) check("t2_done_cycle", done_q[0], 27);
    check("t2_n_load", n_ld, 1);
    check("t2_n_read", n_rd, 6);
    check("t2_n_write", n_wr, 6);
    check("t2_n_swap", n_sw, 1);
    check("t2_order_len", rd_q.size(), 6);
    for (int i = 0; i < 6 && i < rd_q.size(); i++) check($sformatf("t2_order%0d", i), rd_q[i], exp_order[i]);
    check("t2_busy_in_done", busy_h[27], 1);
    check("t2_idle_after_done", busy_h[28], 0);

    // Test 3: start pulses while busy are ignored
    run(0, 40, 1'b0, 5, 12, -1);
    check("t3_n_done", done_q.size(), 1);
    if (done_q.size() > 0) check("t3_done_cycle", done_q[0], 27);
    check("t3_n_load", n_ld, 1);

    // Test 4: abort in layer1/neuron1 COMP (cycle 20), then a clean run
    run(0, 40, 1'b0, -1, -1, 20);
    check("t4_n_done", done_q.size(), 0);
    check("t4_n_write", n_wr, 4);
    check("t4_idle_next", busy_h[21], 0);
    run(0, 40, 1'b0, -1, -1, -1);
    check("t4_rerun_n_done", done_q.size(), 1);
    if (done_q.size() > 0) check("t4_rerun_cycle", done_q[0], 27);

    // Test 5: start held high
    run(0, 60, 1'b1, -1, -1, -1);
    check("t5_n_done", done_q.size(), 2);
    if (done_q.size() >= 2) begin
      check("t5_first_done", done_q[0], 27);
      check("t5_period", done_q[1] - done_q[0], 28);
      check("t5_one_idle", busy_h[done_q[0] + 1], 0);
      check("t5_restart", busy_h[done_q[0] + 2], 1);
    end

    // Test 6: M=4, N=2, NEU_LAT=1
    run(1, 30, 1'b0, -1, -1, -1);
    check("t6_n_done", done_q.size(), 1);
    if (done_q.size() > 0) check("t6_done_cycle", done_q[0], 22);
    check("t6_n_swap", n_sw, 2);
    check("t6_n_read", n_rd, 6);
    check("t6_n_write", n_wr, 6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
